// File: rtl/imem_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : imem_if                                                   |
// | Purpose  : Fetch-side request/response channel for instruction RAM.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface imem_if;
   logic        request;
   logic        we_re;
   logic [3:0]  mask;
   logic [31:0] address;
   logic [31:0] data_in;
   logic        flush;
   logic        valid;
   logic [31:0] data_out;
   logic        err;

   modport master (
      output request, we_re, mask, address, data_in, flush,
      input  valid, data_out, err
   );

   modport slave (
      input  request, we_re, mask, address, data_in, flush,
      output valid, data_out, err
   );
endinterface
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : imem_responder                                            |
// | Purpose  : Fixed-latency instruction RAM responder with byte-masked  |
// |            program-load writes and in-flight response flush.         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module imem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 1,
   parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
   input  wire logic clk,
   input  wire logic rst,
   imem_if.slave     bus
);

   localparam int c_AW = $clog2(DEPTH_WORDS);

   logic [31:0]       r_mem [DEPTH_WORDS];

   logic [c_AW-1:0]   w_idx;
   logic              w_misaligned;
   logic              w_out_of_range;
   logic              w_err;
   logic              w_write;
   logic [31:0]       w_cur;
   logic [31:0]       w_merged;
   logic [31:0]       w_rsp;

   logic [LATENCY-1:0] r_v;
   logic [LATENCY-1:0] r_e;
   logic [31:0]        r_d [LATENCY];

   logic [LATENCY-1:0] w_in_v;
   logic [LATENCY-1:0] w_in_e;
   logic [31:0]        w_in_d [LATENCY];

   assign w_idx          = bus.address[c_AW+1:2];
   assign w_misaligned   = |bus.address[1:0];
   assign w_out_of_range = |bus.address[31:c_AW+2];
   assign w_err          = w_misaligned | w_out_of_range;
   assign w_cur          = r_mem[w_idx];

   // Word as it will look after this request; equals w_cur for mask 0.
   always_comb begin
      w_merged = w_cur;
      for (int b = 0; b < 4; b++) begin
         if (bus.mask[b]) begin
            w_merged[8*b +: 8] = bus.data_in[8*b +: 8];
         end
      end
   end

   assign w_rsp   = w_err ? NOP_WORD : (bus.we_re ? w_merged : w_cur);
   assign w_write = rst & bus.request & bus.we_re & ~w_err;

   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[w_idx] <= w_merged;
      end
   end

   // Stage 0 captures the new request, which a same-cycle flush never kills.
   always_comb begin
      w_in_v[0] = bus.request;
      w_in_e[0] = w_err;
      w_in_d[0] = w_rsp;
      for (int i = 1; i < LATENCY; i++) begin
         w_in_v[i] = r_v[i-1] & ~bus.flush;
         w_in_e[i] = r_e[i-1];
         w_in_d[i] = r_d[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_v <= '0;
         r_e <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            r_d[i] <= NOP_WORD;
         end
      end else begin
         for (int i = 0; i < LATENCY - 1; i++) begin
            r_v[i] <= w_in_v[i];
            r_e[i] <= w_in_e[i];
            r_d[i] <= w_in_d[i];
         end
         // Output stage: data holds while idle, err only alongside valid.
         r_v[LATENCY-1] <= w_in_v[LATENCY-1];
         r_e[LATENCY-1] <= w_in_v[LATENCY-1] & w_in_e[LATENCY-1];
         if (w_in_v[LATENCY-1]) begin
            r_d[LATENCY-1] <= w_in_d[LATENCY-1];
         end
      end
   end

   assign bus.valid    = r_v[LATENCY-1];
   assign bus.err      = r_e[LATENCY-1];
   assign bus.data_out = r_d[LATENCY-1];

endmodule
`default_nettype wire
